// File: rtl/t_toggle_pkg.sv
// Shared constants and queue-state encoding for toggle-encoded event decoders.
// No logic; latency and backpressure are properties of the modules that import it.
// Queue states mirror pend_cnt occupancy and are kept for debug visibility.
package t_toggle_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int PEND_W_DEF      = 4;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_HOLD  = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    function automatic q_state_t q_state_of(input logic is_zero, input logic is_max);
        if (is_zero)
            return Q_EMPTY;
        else if (is_max)
            return Q_FULL;
        else
            return Q_HOLD;
    endfunction

endpackage

// File: rtl/t_sync_chain.sv
// N-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: N clk cycles from the first-stage capture to q.
// No backpressure; the input is sampled every cycle.
module t_sync_chain
    import t_toggle_pkg::*;
#(
    parameter int N = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst)
            ff <= '0;
        else
            ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/t_toggle_decoder.sv
// Decodes a toggle-encoded event line into pulses, a pending-event queue and a total count.
// Latency: SYNC_STAGES+1 clk cycles from first-stage capture of t_in to evt_pulse.
// Backpressure: events queue up to 2**PEND_W-1; further events are dropped and flag overflow.
module t_toggle_decoder
    import t_toggle_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int PEND_W      = PEND_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_in,
    input  logic              en,
    input  logic              clr_ovf,
    input  logic              evt_ready,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  evt_total,
    output logic              overflow,
    output logic              level
);

    localparam logic [2:0]        ARM_DONE = 3'(SYNC_STAGES + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              level_s;
    logic              prev;
    logic [2:0]        arm_cnt;
    logic              armed;
    logic              hit;
    logic              push;
    logic              pop;
    q_state_t          q_state;
    q_state_t          q_state_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;

    t_sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (t_in),
        .q   (level_s)
    );

    assign level = level_s;

    // Arming hides the reset-release transition of a line that was already high.
    assign armed = (arm_cnt == ARM_DONE);
    assign hit   = (level_s ^ prev) & en & armed;
    assign push  = hit;
    assign pop   = evt_valid & evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= 1'b0;
            arm_cnt   <= '0;
            evt_pulse <= 1'b0;
            evt_total <= '0;
        end else begin
            prev      <= level_s;
            if (!armed)
                arm_cnt <= arm_cnt + 3'd1;
            evt_pulse <= hit;
            if (hit)
                evt_total <= evt_total + CNT_W'(1);
        end
    end

    always_comb begin
        pend_nxt = pend_cnt;
        ovf_nxt  = clr_ovf ? 1'b0 : overflow;
        case (q_state)
            Q_EMPTY: begin
                if (push)
                    pend_nxt = pend_cnt + PEND_W'(1);
            end
            Q_HOLD: begin
                if (push && !pop)
                    pend_nxt = pend_cnt + PEND_W'(1);
                else if (pop && !push)
                    pend_nxt = pend_cnt - PEND_W'(1);
            end
            Q_FULL: begin
                if (pop && !push)
                    pend_nxt = pend_cnt - PEND_W'(1);
                else if (push && !pop)
                    ovf_nxt = 1'b1;
            end
            default: pend_nxt = pend_cnt;
        endcase
        q_state_nxt = q_state_of(pend_nxt == '0, pend_nxt == PEND_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_state   <= Q_EMPTY;
            pend_cnt  <= '0;
            evt_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            q_state   <= q_state_nxt;
            pend_cnt  <= pend_nxt;
            evt_valid <= (pend_nxt != '0);
            overflow  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_t_toggle_decoder.sv
// Table-driven bench with a pulse-timing scoreboard for t_toggle_decoder.
module tb_t_toggle_decoder;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_in;
    logic       en;
    logic       clr_ovf;
    logic       evt_ready;
    logic       evt_pulse;
    logic       evt_valid;
    logic [3:0] pend_cnt;
    logic [7:0] evt_total;
    logic       overflow;
    logic       level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int exp_q[$];

    typedef struct {
        int n_tog;
        bit en;
        bit drain_first;
        bit rst_first;
        bit clr_first;
        int exp_pend;
        int exp_total;
        bit exp_ovf;
    } vec_t;

    vec_t tbl[4];

    t_toggle_decoder #(.SYNC_STAGES(SS), .PEND_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .t_in      (t_in),
        .en        (en),
        .clr_ovf   (clr_ovf),
        .evt_ready (evt_ready),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .evt_total (evt_total),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every pulse must match the oldest outstanding toggle's expected cycle.
    always @(negedge clk) begin
        if (!rst && evt_pulse) begin
            pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    n_fail++;
                    $display("FAIL pulse_timing: pulse at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pulse"}, 32'(evt_pulse), 0);
        chk({tag, "_valid"}, 32'(evt_valid), 0);
        chk({tag, "_pend"},  32'(pend_cnt),  0);
        chk({tag, "_total"}, 32'(evt_total), 0);
        chk({tag, "_ovf"},   32'(overflow),  0);
        chk({tag, "_level"}, 32'(level),     0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (SS + 2) tick();
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("drain_pend_%0d", k), 32'(pend_cnt), k);
            chk($sformatf("drain_valid_%0d", k), 32'(evt_valid), (k != 0) ? 1 : 0);
        end
        tick();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("no_underflow", 32'(pend_cnt), 0);
    endtask

    task automatic clr();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_pend", 32'(pend_cnt), 15);
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int p0;
        if (v.drain_first) drain();
        if (v.rst_first) do_reset();
        if (v.clr_first) clr();
        tick();
        en = v.en;
        p0 = pulses;
        for (int k = 0; k < v.n_tog; k++) begin
            t_in = ~t_in;
            if (v.en) exp_q.push_back(cyc + SS + 1);
            repeat (4) tick();
        end
        repeat (4) tick();
        en = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk($sformatf("row%0d_pend", idx),   32'(pend_cnt),  v.exp_pend);
        chk($sformatf("row%0d_total", idx),  32'(evt_total), v.exp_total);
        chk($sformatf("row%0d_ovf", idx),    32'(overflow),  32'(v.exp_ovf));
        chk($sformatf("row%0d_valid", idx),  32'(evt_valid), (v.exp_pend != 0) ? 1 : 0);
        chk($sformatf("row%0d_pulses", idx), pulses - p0,    v.en ? v.n_tog : 0);
    endtask

    initial begin
        tbl[0] = '{n_tog: 5,  en: 1, drain_first: 0, rst_first: 0, clr_first: 0,
                   exp_pend: 5,  exp_total: 5,  exp_ovf: 0};
        tbl[1] = '{n_tog: 17, en: 1, drain_first: 1, rst_first: 1, clr_first: 0,
                   exp_pend: 15, exp_total: 17, exp_ovf: 1};
        tbl[2] = '{n_tog: 3,  en: 0, drain_first: 0, rst_first: 0, clr_first: 1,
                   exp_pend: 15, exp_total: 17, exp_ovf: 0};
        tbl[3] = '{n_tog: 2,  en: 1, drain_first: 0, rst_first: 0, clr_first: 0,
                   exp_pend: 15, exp_total: 19, exp_ovf: 1};

        rst = 1'b1; t_in = 1'b1; en = 1'b1; clr_ovf = 1'b0; evt_ready = 1'b0;

        // Reset with the line already high; release must not produce an event.
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("hold_high_total", 32'(evt_total), 0);
        chk("hold_high_pend",  32'(pend_cnt),  0);
        chk("hold_high_level", 32'(level),     1);

        for (int i = 0; i < 4; i++) run_row(i, tbl[i]);

        // Simultaneous push and pop while full.
        clr();
        tick();
        t_in = ~t_in;
        exp_q.push_back(cyc + SS + 1);
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_pend",  32'(pend_cnt),  15);
        chk("pushpop_ovf",   32'(overflow),  0);
        chk("pushpop_valid", 32'(evt_valid), 1);
        chk("pushpop_total", 32'(evt_total), 20);

        // Reset while a toggle is still in flight.
        tick();
        t_in = ~t_in;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("post_rst_total", 32'(evt_total), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
